// File: rtl/topk_feeder.sv
// topk_feeder: streams LEN scores from a 1-cycle score buffer to the top-K sorter; ReLU when RELU_EN is defined.
module topk_feeder #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [IDX_W-1:0]  base_index,
    input  logic              asce_cfg,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_value,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              clear_reg,
    output logic              asce,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, HOLD, DONE} state_t;
    state_t state;
    logic [ADDR_W:0] cnt, cnt_nx, len_q;
    logic [IDX_W-1:0] base_q;
    logic [DATA_W-1:0] val;
    logic hs_rd;
    assign cnt_nx = cnt + 1'b1;
    // the next read is launched in the handshake cycle so data lands during WAIT
    assign hs_rd = state == HOLD && out_ready && cnt_nx < len_q;
    assign mem_rd_en = state == FETCH || hs_rd;
    assign mem_addr = state == FETCH ? cnt[ADDR_W-1:0] : hs_rd ? cnt_nx[ADDR_W-1:0] : '0;
    assign clear_reg = state == CLEAR;
    assign done = state == DONE;
    assign busy = state != IDLE;
`ifdef RELU_EN
    assign val = mem_rdata[DATA_W-1] ? '0 : mem_rdata;
`else
    assign val = mem_rdata;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            base_q    <= '0;
            asce      <= 1'b0;
            out_value <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= CLEAR;
                    cnt    <= '0;
                    len_q  <= len;
                    base_q <= base_index;
                    asce   <= asce_cfg;
                end
                CLEAR: state <= len_q == '0 ? DONE : FETCH;
                FETCH: state <= WAIT;
                WAIT: begin
                    state     <= HOLD;
                    out_value <= val;
                    out_index <= base_q + IDX_W'(cnt);
                    out_valid <= 1'b1;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    cnt       <= cnt_nx;
                    state     <= cnt_nx < len_q ? WAIT : DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_topk_feeder.sv
// tb_topk_feeder: directed bench for topk_feeder; expected second value follows RELU_EN.
module tb_topk_feeder;
    logic        clk = 0, rst = 1, start = 0, asce_cfg = 0, out_ready = 1;
    logic [10:0] len = '0;
    logic [31:0] base_index = '0, mem_rdata = '0, out_value, out_index;
    logic [9:0]  mem_addr;
    logic        mem_rd_en, out_valid, clear_reg, asce, busy, done;
    logic [31:0] mem [1024];
    int n = 0, errs = 0;
    int got_n, rd_n, done_n, done_cyc, clr_n, valid_n, first_valid, stall_n;
    logic [31:0] got_v [8], got_i [8], sv, si;
    logic [9:0]  rd_a [8];
    bit stall_bad;
`ifdef RELU_EN
    localparam logic [31:0] V1 = 32'h0;
`else
    localparam logic [31:0] V1 = 32'hFFFF_FFFD;
`endif
    logic [31:0] exp_v [4];

    topk_feeder dut (.clk(clk), .rst(rst), .start(start), .len(len), .base_index(base_index),
        .asce_cfg(asce_cfg), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_value(out_value), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
        .clear_reg(clear_reg), .asce(asce), .busy(busy), .done(done));

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'hDEAD_BEEF;

    task automatic start_job(input logic [10:0] l, input logic [31:0] b, input logic a);
        @(negedge clk);
        start = 1; len = l; base_index = b; asce_cfg = a;
        @(negedge clk);
        start = 0; len = '0; base_index = '0; asce_cfg = ~a;
    endtask

    // cycle 1 is the first negedge after the CLEAR cycle
    task automatic collect(input int stall_pair, input int stall_len, input int budget);
        int left = stall_len;
        got_n = 0; rd_n = 0; done_n = 0; done_cyc = -1; clr_n = 0; valid_n = 0;
        first_valid = -1; stall_n = 0; stall_bad = 0; sv = '0; si = '0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            out_ready = !(got_n == stall_pair && out_valid && left > 0);
            #1;
            if (clear_reg) clr_n++;
            if (mem_rd_en) begin if (rd_n < 8) rd_a[rd_n] = mem_addr; rd_n++; end
            if (out_valid) begin valid_n++; if (first_valid < 0) first_valid = c; end
            if (out_valid && !out_ready) begin
                if (stall_n == 0) begin sv = out_value; si = out_index; end
                else if (out_value !== sv || out_index !== si) stall_bad = 1;
                if (mem_rd_en) stall_bad = 1;
                stall_n++; left--;
            end
            if (out_valid && out_ready) begin
                if (got_n < 8) begin got_v[got_n] = out_value; got_i[got_n] = out_index; end
                got_n++;
            end
            if (done) begin done_n++; done_cyc = c; end
            if (done_n > 0 && c >= done_cyc + 2) break;
        end
        out_ready = 1;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        n++; if ({out_valid, clear_reg, busy, done, mem_rd_en, asce} !== 6'b0) begin errs++; $display("FAIL reset_ctrl: got %b want 000000", {out_valid, clear_reg, busy, done, mem_rd_en, asce}); end
        n++; if ({out_value, out_index, mem_addr} !== 74'b0) begin errs++; $display("FAIL reset_data: got %h want 0", {out_value, out_index, mem_addr}); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_stream;
        start_job(11'd4, 32'd100, 1'b1);
        n++; if ({clear_reg, busy, asce} !== 3'b111) begin errs++; $display("FAIL stream_clear: got %b want 111", {clear_reg, busy, asce}); end
        collect(-1, 0, 40);
        n++; if (got_n !== 4) begin errs++; $display("FAIL stream_count: got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            n++; if (got_v[i] !== exp_v[i] || got_i[i] !== 32'd100 + i) begin errs++; $display("FAIL stream_pair%0d: got (%h,%0d) want (%h,%0d)", i, got_v[i], got_i[i], exp_v[i], 100 + i); end
            n++; if (rd_a[i] !== 10'(i)) begin errs++; $display("FAIL stream_addr%0d: got %0d want %0d", i, rd_a[i], i); end
        end
        n++; if (first_valid !== 3) begin errs++; $display("FAIL stream_first_valid: got %0d want 3", first_valid); end
        n++; if (done_cyc !== 10 || done_n !== 1) begin errs++; $display("FAIL stream_done: got cyc %0d cnt %0d want cyc 10 cnt 1", done_cyc, done_n); end
        n++; if (rd_n !== 4 || clr_n !== 0) begin errs++; $display("FAIL stream_rd_clr: got rd %0d clr %0d want rd 4 clr 0", rd_n, clr_n); end
        n++; if ({busy, asce} !== 2'b01) begin errs++; $display("FAIL stream_idle_asce: got %b want 01", {busy, asce}); end
    endtask

    task automatic test_len_zero;
        start_job(11'd0, 32'd7, 1'b0);
        n++; if ({clear_reg, asce} !== 2'b10) begin errs++; $display("FAIL zero_clear: got %b want 10", {clear_reg, asce}); end
        collect(-1, 0, 20);
        n++; if (done_cyc !== 1 || done_n !== 1) begin errs++; $display("FAIL zero_done: got cyc %0d cnt %0d want cyc 1 cnt 1", done_cyc, done_n); end
        n++; if (valid_n !== 0 || rd_n !== 0 || clr_n !== 0) begin errs++; $display("FAIL zero_quiet: got valid %0d rd %0d clr %0d want 0 0 0", valid_n, rd_n, clr_n); end
    endtask

    task automatic test_stall;
        start_job(11'd4, 32'd200, 1'b0);
        collect(1, 5, 60);
        n++; if (stall_n !== 5 || stall_bad) begin errs++; $display("FAIL stall_stable: got cycles %0d bad %0d want 5 0", stall_n, stall_bad); end
        n++; if (sv !== V1 || si !== 32'd201) begin errs++; $display("FAIL stall_value: got (%h,%0d) want (%h,201)", sv, si, V1); end
        n++; if (got_n !== 4 || got_v[1] !== V1 || got_v[2] !== 32'd7 || got_i[3] !== 32'd203) begin errs++; $display("FAIL stall_pairs: got n %0d v1 %h v2 %h i3 %0d want 4 %h 7 203", got_n, got_v[1], got_v[2], got_i[3], V1); end
        n++; if (done_cyc !== 15) begin errs++; $display("FAIL stall_done: got %0d want 15", done_cyc); end
    endtask

    task automatic test_index_wrap;
        start_job(11'd2, 32'hFFFF_FFFF, 1'b1);
        collect(-1, 0, 30);
        n++; if (got_n !== 2 || got_i[0] !== 32'hFFFF_FFFF || got_i[1] !== 32'h0) begin errs++; $display("FAIL wrap_index: got n %0d i0 %h i1 %h want 2 ffffffff 00000000", got_n, got_i[0], got_i[1]); end
    endtask

    task automatic test_reset_mid_job;
        int hs = 0;
        bit hit = 0;
        start_job(11'd4, 32'd300, 1'b1);
        for (int c = 1; c <= 40 && !hit; c++) begin
            @(negedge clk);
            if (out_valid && hs == 2) begin hit = 1; rst = 1; out_ready = 0; end
            else if (out_valid) hs++;
        end
        n++; if (!hit) begin errs++; $display("FAIL midrst_reach: got 0 want 1"); end
        @(negedge clk);
        #1;
        n++; if ({out_valid, clear_reg, busy, done, mem_rd_en, asce, out_value, out_index, mem_addr} !== 80'b0) begin errs++; $display("FAIL midrst_zero: got %h want 0", {out_valid, clear_reg, busy, done, mem_rd_en, asce, out_value, out_index, mem_addr}); end
        rst = 0; out_ready = 1;
        collect(-1, 0, 6);
        n++; if (done_n !== 0 || clr_n !== 0 || valid_n !== 0) begin errs++; $display("FAIL midrst_quiet: got done %0d clr %0d valid %0d want 0 0 0", done_n, clr_n, valid_n); end
        start_job(11'd4, 32'd300, 1'b1);
        collect(-1, 0, 40);
        n++; if (rd_a[0] !== 10'd0 || got_n !== 4 || got_v[0] !== 32'd5 || got_i[0] !== 32'd300 || done_n !== 1) begin errs++; $display("FAIL midrst_rerun: got a0 %0d n %0d v0 %h i0 %0d done %0d want 0 4 5 300 1", rd_a[0], got_n, got_v[0], got_i[0], done_n); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
        mem[0] = 32'd5; mem[1] = 32'hFFFF_FFFD; mem[2] = 32'd7; mem[3] = 32'd0;
        exp_v[0] = 32'd5; exp_v[1] = V1; exp_v[2] = 32'd7; exp_v[3] = 32'd0;
        test_reset;
        test_stream;
        test_len_zero;
        test_stall;
        test_index_wrap;
        test_reset_mid_job;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
        $finish;
    end
endmodule
